neuron_update_ctrl: RTL and testbench

Sequencing controller that sits directly upstream of the time-multiplexed LIF neuron core. It accepts presynaptic input events and time-reference (leak) requests and sweeps all N neurons. For each neuron it issues the read and write-back cycles to the neuron core and the matching synapse-memory read. Output spikes from the core are captured into a one-entry AER output register with valid/ready handshake, and the sweep back-pressures when that register is occupied.

---
 rtl/neuron_ctrl_pkg.sv | 8 +
 rtl/aer_spike_reg.sv | 30 +++
 rtl/neuron_update_ctrl.sv | 114 +++++++++++
 tb/tb_neuron_update_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_ctrl_pkg.sv
// neuron_ctrl_pkg: shared types and constants for the neuron update controller.
package neuron_ctrl_pkg;
    localparam int WEIGHTS_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    function automatic int syn_aw(input int m);
        return 2 * m - 2;
    endfunction
endpackage

// File: rtl/aer_spike_reg.sv
// aer_spike_reg: one-entry valid/ready holding register; a load wins over a same-cycle drain.
module aer_spike_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] addr_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] addr_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] addr_q, addr_d;
    always_comb begin
        valid_d = load_i | (valid_q & ~ready_i);
        addr_d  = load_i ? addr_i : addr_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end
    assign valid_o = valid_q;
    assign addr_o  = addr_q;
endmodule

// File: rtl/neuron_update_ctrl.sv
// neuron_update_ctrl: sweeps all neurons per event/tref request, issuing read and
// write-back cycles to the neuron core, and stalls reads while the spike register is full.
module neuron_update_ctrl
    import neuron_ctrl_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 2 ** M
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   event_valid_i,
    input  logic [M-1:0]           event_addr_i,
    output logic                   event_ready_o,
    input  logic                   tref_valid_i,
    output logic                   tref_ready_o,
    output logic                   synarray_cs_o,
    output logic [syn_aw(M)-1:0]   synarray_addr_o,
    output logic                   neuron_event_o,
    output logic                   neuron_write_o,
    output logic                   neuron_tref_o,
    output logic [M-1:0]           neuron_idx_o,
    output logic [M-1:0]           count_o,
    input  logic                   neuron_spike_i,
    output logic                   spike_valid_o,
    output logic [M-1:0]           spike_addr_o,
    input  logic                   spike_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int SHIFT = $clog2(WEIGHTS_PER_WORD);
    state_t               state_q, state_d;
    logic [M-1:0]         count_q, count_d, idx_q, idx_d;
    logic                 tref_q, tref_d, done_q, done_d, busy_q, busy_d;
    logic                 ev_q, ev_d, wr_q, wr_d, cs_q, cs_d;
    logic [syn_aw(M)-1:0] addr_q, addr_d;
    logic                 drain_ok;
    assign drain_ok = ~spike_valid_o | spike_ready_i;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        tref_d  = tref_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tref_valid_i || event_valid_i) begin
                state_d = READ;
                count_d = '0;
                tref_d  = tref_valid_i;
                idx_d   = tref_valid_i ? idx_q : event_addr_i;
            end
            READ: state_d = drain_ok ? WRITE : READ;
            WRITE: if (count_q == M'(N - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                tref_d  = 1'b0;
            end else begin
                state_d = READ;
                count_d = count_q + M'(1);
            end
            default: state_d = IDLE;
        endcase
        // strobes are registered, so they are decoded from the next state
        ev_d   = state_d != IDLE;
        busy_d = state_d != IDLE;
        wr_d   = state_d == WRITE;
        cs_d   = (state_d == READ) & ~tref_d;
        addr_d = {idx_d, count_d[M-1:SHIFT]};
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            tref_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ev_q    <= 1'b0;
            wr_q    <= 1'b0;
            cs_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            tref_q  <= tref_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ev_q    <= ev_d;
            wr_q    <= wr_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
        end
    end
    aer_spike_reg #(.W(M)) u_spike (
        .clk     (CLK),
        .rst     (RST),
        .load_i  ((state_q == WRITE) & neuron_spike_i),
        .addr_i  (count_q),
        .ready_i (spike_ready_i),
        .valid_o (spike_valid_o),
        .addr_o  (spike_addr_o)
    );
    assign event_ready_o   = state_q == IDLE;
    assign tref_ready_o    = state_q == IDLE;
    assign synarray_cs_o   = cs_q;
    assign synarray_addr_o = addr_q;
    assign neuron_event_o  = ev_q;
    assign neuron_write_o  = wr_q;
    assign neuron_tref_o   = tref_q;
    assign neuron_idx_o    = idx_q;
    assign count_o         = count_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
endmodule

// File: tb/tb_neuron_update_ctrl.sv
// tb_neuron_update_ctrl: table-driven sweeps with synapse-address and spike scoreboards,
// plus hand-written tref/event priority and mid-sweep reset sequences.
module tb_neuron_update_ctrl;
    localparam int M = 8;
    localparam int N = 256;
    logic         CLK = 1'b0, RST = 1'b1;
    logic         event_valid_i = 1'b0, tref_valid_i = 1'b0;
    logic [M-1:0] event_addr_i = '0;
    logic         neuron_spike_i = 1'b0, spike_ready_i = 1'b1;
    logic         event_ready_o, tref_ready_o, synarray_cs_o;
    logic [13:0]  synarray_addr_o;
    logic         neuron_event_o, neuron_write_o, neuron_tref_o;
    logic [M-1:0] neuron_idx_o, count_o, spike_addr_o;
    logic         spike_valid_o, busy_o, done_o;
    typedef struct {
        bit         tref;
        logic [7:0] pre;
        int         sp_a;
        int         sp_b;
        int         hold;
        int         stall;
        int         cyc;
    } vec_t;
    vec_t        tbl[4];
    logic [13:0] aq[$];
    int          sq[$];
    int          checks = 0, errors = 0;
    bit          cur_tref = 1'b0;
    int          sp_a = -1, sp_b = -1, hold = 0;
    always #5 CLK = ~CLK;
    neuron_update_ctrl dut (
        .CLK(CLK), .RST(RST),
        .event_valid_i(event_valid_i), .event_addr_i(event_addr_i), .event_ready_o(event_ready_o),
        .tref_valid_i(tref_valid_i), .tref_ready_o(tref_ready_o),
        .synarray_cs_o(synarray_cs_o), .synarray_addr_o(synarray_addr_o),
        .neuron_event_o(neuron_event_o), .neuron_write_o(neuron_write_o),
        .neuron_tref_o(neuron_tref_o), .neuron_idx_o(neuron_idx_o), .count_o(count_o),
        .neuron_spike_i(neuron_spike_i), .spike_valid_o(spike_valid_o),
        .spike_addr_o(spike_addr_o), .spike_ready_i(spike_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk_reset();
        check("rst_busy", busy_o, 0);
        check("rst_event", neuron_event_o, 0);
        check("rst_write", neuron_write_o, 0);
        check("rst_cs", synarray_cs_o, 0);
        check("rst_addr", synarray_addr_o, 0);
        check("rst_idx", neuron_idx_o, 0);
        check("rst_tref", neuron_tref_o, 0);
        check("rst_count", count_o, 0);
        check("rst_spv", spike_valid_o, 0);
        check("rst_spa", spike_addr_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ev_rdy", event_ready_o, 1);
        check("rst_tref_rdy", tref_ready_o, 1);
    endtask
    task automatic fill(input logic [7:0] pre);
        for (int c = 0; c < N; c++) begin
            logic [7:0] cc;
            cc = 8'(c);
            aq.push_back({pre, cc[7:2]});
        end
    endtask
    task automatic start(input bit t, input logic [7:0] a);
        check("ev_rdy", event_ready_o, 1);
        check("tref_rdy", tref_ready_o, 1);
        tref_valid_i = t;
        event_valid_i = !t;
        event_addr_i = a;
        if (!t) fill(a);
        @(negedge CLK);
        tref_valid_i = 0;
        event_valid_i = 0;
        check("busy_start", busy_o, 1);
        if (!t) check("idx", neuron_idx_o, a);
    endtask
    task automatic run(input int abort_at, input int exp_cyc, input int exp_stall);
        int          cyc = 1, stalls = 0, exp_cnt = 0;
        bit          prev_rd = 0;
        logic [13:0] last = '0;
        while (busy_o && cyc < 2 * N + 64) begin
            neuron_spike_i = 0;
            check("done_early", done_o, 0);
            check("tref", neuron_tref_o, cur_tref);
            check("access", neuron_event_o, 1);
            if (!neuron_write_o) begin
                check("count_rd", count_o, exp_cnt);
                check("cs_rd", synarray_cs_o, !cur_tref);
                if (int'(count_o) == abort_at) return;
                if (prev_rd) begin
                    stalls++;
                    if (synarray_cs_o) check("addr_rep", synarray_addr_o, last);
                end else if (synarray_cs_o) begin
                    if (aq.size() == 0) check("aq_empty", 1, 0);
                    else begin
                        last = aq.pop_front();
                        check("syn_addr", synarray_addr_o, last);
                    end
                end
                prev_rd = 1;
            end else begin
                check("count_wr", count_o, exp_cnt);
                check("cs_wr", synarray_cs_o, 0);
                if (exp_cnt == sp_a || exp_cnt == sp_b) begin
                    neuron_spike_i = 1;
                    sq.push_back(exp_cnt);
                end
                exp_cnt++;
                prev_rd = 0;
            end
            if (spike_valid_o && hold > 0) begin
                spike_ready_i = 0;
                hold--;
            end else spike_ready_i = 1;
            if (spike_valid_o && spike_ready_i) begin
                if (sq.size() == 0) check("sq_empty", 1, 0);
                else check("spike_addr", spike_addr_o, sq.pop_front());
            end
            @(negedge CLK);
            cyc++;
        end
        neuron_spike_i = 0;
        check("sweep_cycles", cyc - 1, exp_cyc);
        check("stalls", stalls, exp_stall);
        check("done", done_o, 1);
        check("busy_end", busy_o, 0);
        check("aq_left", aq.size(), 0);
        check("sq_left", sq.size(), 0);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{0, 8'h05, -1, -1, 0, 0, 512};
        tbl[1] = '{0, 8'hA3, 7, -1, 5, 5, 517};
        tbl[2] = '{0, 8'hFF, 3, 4, 0, 0, 512};
        tbl[3] = '{1, 8'h00, 0, 200, 0, 0, 512};
        repeat (2) @(negedge CLK);
        chk_reset();
        RST = 0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            cur_tref = tbl[i].tref;
            sp_a = tbl[i].sp_a;
            sp_b = tbl[i].sp_b;
            hold = tbl[i].hold;
            start(tbl[i].tref, tbl[i].pre);
            run(-1, tbl[i].cyc, tbl[i].stall);
        end
        // simultaneous tref and event: tref first, event taken as soon as the sweep ends
        cur_tref = 1;
        sp_a = -1;
        sp_b = -1;
        hold = 0;
        tref_valid_i = 1;
        event_valid_i = 1;
        event_addr_i = 8'h5A;
        @(negedge CLK);
        tref_valid_i = 0;
        check("tref_first", neuron_tref_o, 1);
        run(-1, 512, 0);
        check("ev_rdy_at_done", event_ready_o, 1);
        fill(8'h5A);
        cur_tref = 0;
        @(negedge CLK);
        event_valid_i = 0;
        check("idx_5a", neuron_idx_o, 8'h5A);
        check("busy_5a", busy_o, 1);
        run(-1, 512, 0);
        // reset mid-sweep with a spike pending
        sp_a = 99;
        hold = 1000;
        start(0, 8'h33);
        run(100, 0, 0);
        check("abort_count", count_o, 100);
        check("pending_spike", spike_valid_o, 1);
        RST = 1;
        #1;
        chk_reset();
        aq.delete();
        sq.delete();
        @(negedge CLK);
        RST = 0;
        hold = 0;
        sp_a = -1;
        spike_ready_i = 1;
        @(negedge CLK);
        start(0, 8'h12);
        run(-1, 512, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
